miriscv_mem_model: RTL and testbench
====================================

# miriscv_mem_model

Parametrised, synthesizable dual-channel memory model that services the miriscv core's instruction-fetch and data buses from one shared word array. It adds configurable response latency, byte-enable writes, an address window with an out-of-range error flag, and pipelined back-to-back requests. It sits in the testbench top between the core and the memory bus interface, and replaces the fixed single-cycle behavioural memory.

## Interface
Parameters:
- DATA_W, 32: data width; must be 32 in this generation (be is DATA_W/8).
- DEPTH_WORDS, 16384: array depth in words; power of two.
- BASE_ADDR, 32'h8000_0000: byte address of word 0.
- LATENCY, 1: cycles from a sampled req to rvalid; legal range 1..4.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- arst_n  in  1  reset, asynchronous assert, active-low.
- instr_req  in  1  fetch request.
- instr_addr  in  32  fetch byte address.
- instr_rvalid  out  1  fetch response valid.
- instr_rdata  out  32  fetch data.
- instr_err  out  1  fetch address outside the window; valid with instr_rvalid.
- data_req  in  1  data request.
- data_we  in  1  1 = write.
- data_be  in  4  write byte enables.
- data_addr  in  32  data byte address.
- data_wdata  in  32  write data.
- data_rvalid  out  1  data response valid, for both reads and writes.
- data_rdata  out  32  read data; 0 on write responses.
- data_err  out  1  data address outside the window; valid with data_rvalid.

## Operation
- Word index = (addr - BASE_ADDR) >> 2. The address is in range when BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS. addr[1:0] is ignored.
- Each channel accepts one request per cycle; there is no grant and no backpressure.
- Reads sample the array in the request cycle. The result travels down a LATENCY-deep pipeline.
- Writes update the array at the end of the request cycle. Only bytes with be[i]=1 are written. be=0 is a legal no-op write that still gets a response.
- Out-of-range read: rdata=0, err=1. Out-of-range write: array untouched, err=1.
- Same-cycle data write and fetch to the same word: the fetch returns the old data. A fetch one cycle later returns the new data.
- A data write followed by a data read to the same word on the next cycle returns the written data.
- Array contents are not reset. The bench preloads them through hierarchical access or $readmemh.

## Timing
- Reset values: instr_rvalid=0, instr_rdata=0, instr_err=0, data_rvalid=0, data_rdata=0, data_err=0. The pipeline valid bits are all cleared.
- A req sampled high at edge N gives rvalid=1 with its rdata/err during the cycle after edge N+LATENCY-1. With LATENCY=1, the response appears in the cycle after the request.
- Back-to-back requests give back-to-back responses in order. Throughput is 1 per cycle per channel.
- rdata and err hold 0 whenever rvalid=0.
- Reset asserted mid-operation:
  - In-flight responses are dropped; no rvalid is produced for them after reset.
  - Array contents are retained.
  - Writes in the reset cycle are not performed.
- The two channels are fully independent in timing. Simultaneous responses are normal.

## Structure
- Package miriscv_mem_pkg holds:
  - MEM_ADDR_W and MEM_DATA_W constants;
  - default BASE_ADDR;
  - typedef mem_rsp_t {logic valid; logic err; logic [31:0] rdata;};
  - function in_window(addr, base, depth).
- Sub-module miriscv_mem_delay_line, parameter LATENCY:
  - a shift register of mem_rsp_t with async active-low clear;
  - instantiated once per channel.
- The top level holds the array, address decode, byte-enable write merge and read mux.

## Test plan
- LATENCY=1, preload word 0 = 32'h0000_0013:
  - fetch 0x8000_0000 -> instr_rvalid next cycle, rdata 0x0000_0013, err 0.
- LATENCY=3:
  - data writes: 0x8000_0010 ← 0xA5A5_A5A5 with be=4'hF, then be=4'b0010 with wdata 0x0000_3C00;
  - then read the same address -> read response 3 cycles after its request, rdata 0xA5A5_3CA5;
  - each write has rvalid with rdata 0.
- Same cycle: data write 0x1234_5678 to 0x8000_0004 and fetch of 0x8000_0004 (old 0x0) -> fetch returns 0x0. Fetch on the next cycle -> 0x1234_5678.
- Out of range:
  - read 0x7FFF_FFFC -> rvalid, err 1, rdata 0;
  - write 0x8001_0000 (DEPTH 16384) -> err 1;
  - a subsequent read of word 0 is unchanged.
- LATENCY=2, 8 back-to-back fetches of consecutive words:
  - 8 consecutive rvalid cycles, in order, starting 2 cycles after the first request.
- LATENCY=4, 2 fetches in flight, arst_n pulsed low for 1 cycle:
  - no rvalid afterwards, all outputs 0 during reset;
  - a new fetch after release returns the preloaded data.

Source files
------------

// File: rtl/miriscv_mem_pkg.sv
// Shared types and helpers for the miriscv memory model.
//   MEM_ADDR_W / MEM_DATA_W : bus address and data widths
//   MEM_BASE_ADDR           : default byte address of word 0
//   mem_rsp_t               : one response beat travelling down a delay line
//   in_window()             : address-window check used by both channels
package miriscv_mem_pkg;

    localparam int unsigned MEM_ADDR_W = 32;
    localparam int unsigned MEM_DATA_W = 32;

    localparam logic [MEM_ADDR_W-1:0] MEM_BASE_ADDR = 32'h8000_0000;

    typedef struct packed {
        logic                  valid;
        logic                  err;
        logic [MEM_DATA_W-1:0] rdata;
    } mem_rsp_t;

    // True when base <= addr < base + 4*depth. The subtraction is done one bit
    // wider so that an address below base shows up as a borrow instead of
    // wrapping around into the window.
    function automatic logic in_window(
        input logic [MEM_ADDR_W-1:0] addr,
        input logic [MEM_ADDR_W-1:0] base,
        input int unsigned           depth
    );
        logic [MEM_ADDR_W:0] off;
        logic [MEM_ADDR_W:0] span;
        off  = {1'b0, addr} - {1'b0, base};
        span = {1'b0, depth} << 2;
        return !off[MEM_ADDR_W] && (off < span);
    endfunction

endpackage

// File: rtl/miriscv_mem_delay_line.sv
// Fixed-latency response pipeline for one memory channel.
//   clk    : clock, rising edge
//   arst_n : asynchronous active-low clear of every stage
//   sample : response formed in the request cycle
//   result : the same response LATENCY cycles later
module miriscv_mem_delay_line
    import miriscv_mem_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic     clk,
    input  logic     arst_n,
    input  mem_rsp_t sample,
    output mem_rsp_t result
);

    mem_rsp_t stage [LATENCY];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= sample;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign result = stage[LATENCY-1];

endmodule

// File: rtl/miriscv_mem_model.sv
// Dual-channel memory model for the miriscv core: instruction fetch and data
// access share one word array. Requests are accepted every cycle and answered
// after LATENCY cycles; addresses outside the window answer with err=1.
//   clk, arst_n                          : clock, async active-low reset
//   instr_req/instr_addr                 : fetch request
//   instr_rvalid/instr_rdata/instr_err   : fetch response
//   data_req/data_we/data_be/data_addr/data_wdata : data request
//   data_rvalid/data_rdata/data_err      : data response (reads and writes)
module miriscv_mem_model
    import miriscv_mem_pkg::*;
#(
    parameter int unsigned           DATA_W      = MEM_DATA_W,
    parameter int unsigned           DEPTH_WORDS = 16384,
    parameter logic [MEM_ADDR_W-1:0] BASE_ADDR   = MEM_BASE_ADDR,
    parameter int unsigned           LATENCY     = 1
) (
    input  logic                  clk,
    input  logic                  arst_n,

    input  logic                  instr_req,
    input  logic [MEM_ADDR_W-1:0] instr_addr,
    output logic                  instr_rvalid,
    output logic [DATA_W-1:0]     instr_rdata,
    output logic                  instr_err,

    input  logic                  data_req,
    input  logic                  data_we,
    input  logic [DATA_W/8-1:0]   data_be,
    input  logic [MEM_ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0]     data_wdata,
    output logic                  data_rvalid,
    output logic [DATA_W-1:0]     data_rdata,
    output logic                  data_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned BE_W  = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    logic [MEM_ADDR_W-1:0] instr_off;
    logic [MEM_ADDR_W-1:0] data_off;
    logic [IDX_W-1:0]      instr_idx;
    logic [IDX_W-1:0]      data_idx;
    logic                  instr_hit;
    logic                  data_hit;
    logic                  data_wr;

    mem_rsp_t instr_sample;
    mem_rsp_t data_sample;
    mem_rsp_t instr_rsp;
    mem_rsp_t data_rsp;

    // Address decode: byte offset from the window base, word index from its
    // upper bits; addr[1:0] never reaches the index.
    always_comb begin
        instr_off = instr_addr - BASE_ADDR;
        data_off  = data_addr - BASE_ADDR;
        instr_idx = IDX_W'(instr_off >> 2);
        data_idx  = IDX_W'(data_off >> 2);
        instr_hit = in_window(instr_addr, BASE_ADDR, DEPTH_WORDS);
        data_hit  = in_window(data_addr, BASE_ADDR, DEPTH_WORDS);
    end

    // Both channels read the array combinationally in the request cycle, so a
    // fetch that coincides with a data write to the same word sees the old
    // contents; the write lands on the closing edge.
    always_comb begin
        instr_sample = '0;
        if (instr_req) begin
            instr_sample.valid = 1'b1;
            instr_sample.err   = !instr_hit;
            instr_sample.rdata = instr_hit ? mem[instr_idx] : '0;
        end

        data_sample = '0;
        if (data_req) begin
            data_sample.valid = 1'b1;
            data_sample.err   = !data_hit;
            data_sample.rdata = (data_hit && !data_we) ? mem[data_idx] : '0;
        end

        data_wr = data_req && data_we && data_hit;
    end

    // Array contents survive reset; only the write itself is suppressed while
    // arst_n is low.
    always_ff @(posedge clk) begin
        if (arst_n && data_wr) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
                if (data_be[i]) begin
                    mem[data_idx][8*i +: 8] <= data_wdata[8*i +: 8];
                end
            end
        end
    end

    miriscv_mem_delay_line #(
        .LATENCY (LATENCY)
    ) u_instr_dly (
        .clk    (clk),
        .arst_n (arst_n),
        .sample (instr_sample),
        .result (instr_rsp)
    );

    miriscv_mem_delay_line #(
        .LATENCY (LATENCY)
    ) u_data_dly (
        .clk    (clk),
        .arst_n (arst_n),
        .sample (data_sample),
        .result (data_rsp)
    );

    // Samples are zero-filled when not valid, so rdata/err are already 0
    // whenever rvalid is 0.
    always_comb begin
        instr_rvalid = instr_rsp.valid;
        instr_err    = instr_rsp.err;
        instr_rdata  = instr_rsp.rdata;
        data_rvalid  = data_rsp.valid;
        data_err     = data_rsp.err;
        data_rdata   = data_rsp.rdata;
    end

endmodule

// File: tb/tb_miriscv_mem_model.sv
// Bench for miriscv_mem_model: four instances (LATENCY 1..4) share one input
// stream; a behavioural model logs every request's response by edge number
// and each instance must show the response from LATENCY-1 edges ago.
module tb_miriscv_mem_model;

    localparam int unsigned   DEPTH = 16384;
    localparam logic [31:0]   BASE  = 32'h8000_0000;

    typedef struct packed {
        logic        v;
        logic        e;
        logic [31:0] d;
    } rsp_t;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;

    logic        i_rvalid [4];
    logic [31:0] i_rdata  [4];
    logic        i_err    [4];
    logic        d_rvalid [4];
    logic [31:0] d_rdata  [4];
    logic        d_err    [4];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        miriscv_mem_model #(
            .DATA_W      (32),
            .DEPTH_WORDS (DEPTH),
            .BASE_ADDR   (BASE),
            .LATENCY     (k + 1)
        ) u_dut (
            .clk          (clk),
            .arst_n       (arst_n),
            .instr_req    (instr_req),
            .instr_addr   (instr_addr),
            .instr_rvalid (i_rvalid[k]),
            .instr_rdata  (i_rdata[k]),
            .instr_err    (i_err[k]),
            .data_req     (data_req),
            .data_we      (data_we),
            .data_be      (data_be),
            .data_addr    (data_addr),
            .data_wdata   (data_wdata),
            .data_rvalid  (d_rvalid[k]),
            .data_rdata   (d_rdata[k]),
            .data_err     (d_err[k])
        );
    end

    // ---------------- behavioural model ----------------
    logic [31:0] mmem [DEPTH];
    rsp_t        ilog [int];
    rsp_t        dlog [int];
    int          edge_cnt = 0;
    int          rst_edge = 0;

    function automatic bit in_win(input logic [31:0] a);
        longint unsigned ua;
        ua = 64'(a);
        return (ua >= 64'(BASE)) && (ua < 64'(BASE) + 64'(4 * DEPTH));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    always @(posedge clk) begin
        rsp_t        ir;
        rsp_t        dr;
        logic [31:0] mask;
        edge_cnt++;
        ir = '0;
        dr = '0;
        if (arst_n) begin
            if (instr_req) begin
                ir.v = 1'b1;
                if (in_win(instr_addr)) ir.d = mmem[widx(instr_addr)];
                else                    ir.e = 1'b1;
            end
            if (data_req) begin
                dr.v = 1'b1;
                if (!in_win(data_addr)) begin
                    dr.e = 1'b1;
                end else if (!data_we) begin
                    dr.d = mmem[widx(data_addr)];
                end else begin
                    mask = {{8{data_be[3]}}, {8{data_be[2]}}, {8{data_be[1]}}, {8{data_be[0]}}};
                    mmem[widx(data_addr)] = (mmem[widx(data_addr)] & ~mask) | (data_wdata & mask);
                end
            end
        end
        ilog[edge_cnt] = ir;
        dlog[edge_cnt] = dr;
    end

    // Anything sampled at or before the edge preceding a reset is discarded.
    always @(negedge arst_n) rst_edge = edge_cnt;

    function automatic rsp_t expect_rsp(input bit instr, input int lat);
        int   n;
        rsp_t r;
        n = edge_cnt - lat + 1;
        r = '0;
        if (n >= 1 && n > rst_edge) r = instr ? ilog[n] : dlog[n];
        return r;
    endfunction

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got v/e/d=%0b/%0b/%h expected %0b/%0b/%h",
                     name, $time, act[33], act[32], act[31:0], exp[33], exp[32], exp[31:0]);
        end
    endtask

    always @(negedge clk) begin
        rsp_t e;
        for (int k = 0; k < 4; k++) begin
            e = expect_rsp(1'b1, k + 1);
            chk($sformatf("instr_L%0d", k + 1), {i_rvalid[k], i_err[k], i_rdata[k]}, e);
            e = expect_rsp(1'b0, k + 1);
            chk($sformatf("data_L%0d", k + 1), {d_rvalid[k], d_err[k], d_rdata[k]}, e);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        instr_req  = 1'b0;
        instr_addr = '0;
        data_req   = 1'b0;
        data_we    = 1'b0;
        data_be    = '0;
        data_addr  = '0;
        data_wdata = '0;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic bus_write(input int unsigned w, input logic [31:0] v);
        idle();
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_be    = 4'hF;
        data_addr  = BASE + 32'(4 * w);
        data_wdata = v;
        cyc();
    endtask

    task automatic pulse_reset();
        #2 arst_n = 1'b0;
        @(negedge clk);
        #2 arst_n = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 19);
        if (r < 16)       return BASE + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
        else if (r == 16) return BASE + 32'((DEPTH - 1 - $urandom_range(0, 3)) * 4);
        else if (r == 17) return BASE - 32'(4 * $urandom_range(1, 8));
        else if (r == 18) return BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 8));
        else              return $urandom & 32'h7FFF_FFFF;
    endfunction

    initial begin
        arst_n = 1'b0;
        idle();
        repeat (3) cyc();
        #2 arst_n = 1'b1;
        cyc();

        // Preload through the data port: words 0..63 and the last four words.
        for (int unsigned w = 0; w < 64; w++) begin
            if (w == 0)      bus_write(w, 32'h0000_0013);
            else if (w == 1) bus_write(w, 32'h0000_0000);
            else             bus_write(w, 32'hC0DE_0000 | w);
        end
        for (int unsigned w = DEPTH - 4; w < DEPTH; w++) bus_write(w, 32'hC0DE_0000 | w);
        idle();
        repeat (5) cyc();

        // Fetch word 0, LATENCY=1.
        instr_req = 1'b1; instr_addr = BASE; cyc(); idle();
        chk("fetch0_L1", {i_rvalid[0], i_err[0], i_rdata[0]}, {1'b1, 1'b0, 32'h0000_0013});
        repeat (4) cyc();

        // Full write, byte-lane write, read back; observed on LATENCY=3.
        data_req = 1'b1; data_we = 1'b1; data_be = 4'hF;
        data_addr = BASE + 32'h10; data_wdata = 32'hA5A5_A5A5; cyc();
        data_be = 4'b0010; data_wdata = 32'h0000_3C00; cyc();
        idle(); data_req = 1'b1; data_addr = BASE + 32'h10; cyc(); idle();
        chk("wr1_rsp_L3", {d_rvalid[2], d_err[2], d_rdata[2]}, {1'b1, 1'b0, 32'h0});
        cyc();
        chk("wr2_rsp_L3", {d_rvalid[2], d_err[2], d_rdata[2]}, {1'b1, 1'b0, 32'h0});
        cyc();
        chk("rd_merge_L3", {d_rvalid[2], d_err[2], d_rdata[2]}, {1'b1, 1'b0, 32'hA5A5_3CA5});
        repeat (4) cyc();

        // Same-cycle write and fetch of word 1.
        data_req = 1'b1; data_we = 1'b1; data_be = 4'hF;
        data_addr = BASE + 32'h4; data_wdata = 32'h1234_5678;
        instr_req = 1'b1; instr_addr = BASE + 32'h4; cyc();
        chk("fetch_old_L1", {i_rvalid[0], i_err[0], i_rdata[0]}, {1'b1, 1'b0, 32'h0});
        idle(); instr_req = 1'b1; instr_addr = BASE + 32'h4; cyc(); idle();
        chk("fetch_new_L1", {i_rvalid[0], i_err[0], i_rdata[0]}, {1'b1, 1'b0, 32'h1234_5678});
        repeat (4) cyc();

        // Out-of-range read, out-of-range write, then word 0 unchanged.
        data_req = 1'b1; data_addr = 32'h7FFF_FFFC; cyc(); idle();
        chk("oor_read_L1", {d_rvalid[0], d_err[0], d_rdata[0]}, {1'b1, 1'b1, 32'h0});
        data_req = 1'b1; data_we = 1'b1; data_be = 4'hF;
        data_addr = 32'h8001_0000; data_wdata = 32'hDEAD_BEEF; cyc(); idle();
        chk("oor_write_L1", {d_rvalid[0], d_err[0], d_rdata[0]}, {1'b1, 1'b1, 32'h0});
        data_req = 1'b1; data_addr = BASE; cyc(); idle();
        chk("word0_kept_L1", {d_rvalid[0], d_err[0], d_rdata[0]}, {1'b1, 1'b0, 32'h0000_0013});
        repeat (4) cyc();

        // Eight back-to-back fetches of words 8..15, LATENCY=2.
        instr_req = 1'b1; instr_addr = BASE + 32'h20; cyc();
        chk("b2b_not_early_L2", {i_rvalid[1], i_err[1], i_rdata[1]}, 34'h0);
        for (int j = 0; j < 9; j++) begin
            idle();
            if (j < 7) begin
                instr_req  = 1'b1;
                instr_addr = BASE + 32'(4 * (9 + j));
            end
            cyc();
            if (j < 8)
                chk($sformatf("b2b_%0d_L2", j), {i_rvalid[1], i_err[1], i_rdata[1]},
                    {1'b1, 1'b0, 32'hC0DE_0000 | 32'(8 + j)});
            else
                chk("b2b_end_L2", {i_rvalid[1], i_err[1], i_rdata[1]}, 34'h0);
        end
        repeat (4) cyc();

        // Two fetches in flight on LATENCY=4, then a reset pulse; a write is
        // presented during the reset cycle and must not land.
        instr_req = 1'b1; instr_addr = BASE; cyc();
        instr_addr = BASE + 32'h8; cyc();
        idle(); data_req = 1'b1; data_we = 1'b1; data_be = 4'hF;
        data_addr = BASE + 32'hC; data_wdata = 32'hFFFF_FFFF;
        #2 arst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_instr_L%0d", k + 1), {i_rvalid[k], i_err[k], i_rdata[k]}, 34'h0);
            chk($sformatf("rst_data_L%0d", k + 1), {d_rvalid[k], d_err[k], d_rdata[k]}, 34'h0);
        end
        @(negedge clk);
        #2 arst_n = 1'b1;
        idle();
        for (int j = 0; j < 6; j++) begin
            cyc();
            chk("no_stale_L4", {i_rvalid[3], i_err[3], i_rdata[3]}, 34'h0);
        end
        instr_req = 1'b1; instr_addr = BASE; cyc(); idle();
        repeat (3) cyc();
        chk("post_rst_fetch_L4", {i_rvalid[3], i_err[3], i_rdata[3]}, {1'b1, 1'b0, 32'h0000_0013});
        data_req = 1'b1; data_addr = BASE + 32'hC; cyc(); idle();
        chk("rst_write_dropped_L1", {d_rvalid[0], d_err[0], d_rdata[0]}, {1'b1, 1'b0, 32'hC0DE_0003});
        repeat (4) cyc();

        // Randomised traffic on both channels with occasional resets.
        for (int c = 0; c < 2000; c++) begin
            idle();
            if ($urandom_range(0, 3) != 0) begin
                instr_req  = 1'b1;
                instr_addr = rand_addr();
            end
            if ($urandom_range(0, 3) != 0) begin
                data_req   = 1'b1;
                data_we    = ($urandom_range(0, 9) < 4);
                data_be    = 4'($urandom_range(0, 15));
                data_addr  = rand_addr();
                data_wdata = $urandom;
            end
            if ($urandom_range(0, 249) == 0) pulse_reset();
            else                             cyc();
        end
        idle();
        repeat (6) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: time limit reached before end of stimulus");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
